run_controller: RTL and testbench



---
 rtl/run_controller_if.sv | 21 ++
 rtl/run_controller.sv | 65 ++++++
 tb/tb_run_controller.sv | 129 ++++++++++++
 3 files changed

// File: rtl/run_controller_if.sv
// run_controller_if: host handshake and core start/PC signals of the run sequencer
interface run_controller_if #(
  parameter int PC_BITS  = 10,
  parameter int CNT_BITS = 16
);
  logic                host_req;
  logic                host_ack;
  logic                cpu_start;
  logic [PC_BITS-1:0]  cpu_pc;
  logic                busy;
  logic [CNT_BITS-1:0] cycle_count;
  logic                timed_out;
  modport master (
    output host_req, cpu_pc,
    input  host_ack, cpu_start, busy, cycle_count, timed_out
  );
  modport slave (
    input  host_req, cpu_pc,
    output host_ack, cpu_start, busy, cycle_count, timed_out
  );
endinterface

// File: rtl/run_controller.sv
// run_controller: turns a four-phase host request into a bounded, timed core run
module run_controller #(
  parameter int PC_BITS        = 10,
  parameter int DONE_ADDR      = 435,
  parameter int START_CYCLES   = 2,
  parameter int CNT_BITS       = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic               clock,
  input logic               reset,
  run_controller_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, START, RUN, ACK} state_t;
  state_t              state, state_nx;
  logic [3:0]          hold, hold_nx;
  logic [CNT_BITS-1:0] count, count_nx, count_inc;
  logic                to, to_nx;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      hold  <= '0;
      count <= '0;
      to    <= 1'b0;
    end else begin
      state <= state_nx;
      hold  <= hold_nx;
      count <= count_nx;
      to    <= to_nx;
    end
  end
  // done is checked before the watchdog so a coincident completion is not a timeout
  always_comb begin
    state_nx  = state;
    hold_nx   = hold;
    count_nx  = count;
    to_nx     = to;
    count_inc = count + CNT_BITS'(1);
    case (state)
      IDLE: if (bus.host_req) begin
        state_nx = START;
        hold_nx  = 4'(START_CYCLES);
        count_nx = '0;
        to_nx    = 1'b0;
      end
      START: begin
        hold_nx  = hold - 4'd1;
        state_nx = (hold == 4'd1) ? RUN : START;
      end
      RUN: begin
        count_nx = count_inc;
        if (bus.cpu_pc == PC_BITS'(DONE_ADDR)) state_nx = ACK;
        else if (count_inc == CNT_BITS'(TIMEOUT_CYCLES)) begin
          state_nx = ACK;
          to_nx    = 1'b1;
        end
      end
      ACK: state_nx = bus.host_req ? ACK : IDLE;
    endcase
  end
  assign bus.host_ack    = state == ACK;
  assign bus.cpu_start   = state == START;
  assign bus.busy        = state == START || state == RUN;
  assign bus.cycle_count = count;
  assign bus.timed_out   = to;
endmodule

// File: tb/tb_run_controller.sv
// tb_run_controller: table-driven and randomized runs checked cycle by cycle against spec timing
module tb_run_controller;
  localparam int DONE = 3;
  localparam int TO   = 10;
  localparam int SC   = 2;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad   = 0;
  run_controller_if #(.PC_BITS(10), .CNT_BITS(16)) bus();
  run_controller #(
    .PC_BITS(10), .DONE_ADDR(DONE), .START_CYCLES(SC),
    .CNT_BITS(16), .TIMEOUT_CYCLES(TO)
  ) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  typedef struct {
    int done_at;
    int drop_at;
    bit junk;
    int rst_at;
    int hold;
    int cnt;
    bit to;
  } vec_t;
  vec_t tab[8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask
  function automatic logic [9:0] other_pc();
    logic [9:0] v;
    v = 10'($urandom_range(0, 1023));
    return (v == 10'(DONE)) ? v + 10'd1 : v;
  endfunction
  task automatic chk_cleared(input string tag);
    chk({tag, "_ack"}, bus.host_ack, 0);
    chk({tag, "_start"}, bus.cpu_start, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_count"}, bus.cycle_count, 0);
    chk({tag, "_to"}, bus.timed_out, 0);
  endtask
  // Drives one whole run from IDLE and checks every cycle; rst_at aborts with reset at that RUN cycle
  task automatic run_one(input int done_at, input int drop_at, input bit junk,
                         input int rst_at, input int hold_extra, input int exp_cnt, input bit exp_to);
    chk("idle_ack", bus.host_ack, 0);
    chk("idle_busy", bus.busy, 0);
    bus.host_req = 1'b1;
    bus.cpu_pc   = other_pc();
    tick;
    for (int i = 1; i <= SC; i++) begin
      chk("start_cpu_start", bus.cpu_start, 1);
      chk("start_busy", bus.busy, 1);
      chk("start_ack", bus.host_ack, 0);
      bus.cpu_pc = junk ? 10'(DONE) : other_pc();
      tick;
    end
    for (int r = 1; r <= (rst_at != 0 ? rst_at : exp_cnt); r++) begin
      chk("run_cpu_start", bus.cpu_start, 0);
      chk("run_busy", bus.busy, 1);
      chk("run_ack", bus.host_ack, 0);
      chk("run_count", bus.cycle_count, r - 1);
      if (r == rst_at) begin
        reset        = 1'b1;
        bus.host_req = 1'b0;
        tick;
        chk_cleared("midrst");
        reset = 1'b0;
        return;
      end
      bus.cpu_pc = (r == done_at) ? 10'(DONE) : other_pc();
      if (drop_at != 0 && r >= drop_at) bus.host_req = 1'b0;
      tick;
    end
    chk("ack_ack", bus.host_ack, 1);
    chk("ack_busy", bus.busy, 0);
    chk("ack_cpu_start", bus.cpu_start, 0);
    chk("ack_count", bus.cycle_count, exp_cnt);
    chk("ack_to", bus.timed_out, exp_to);
    for (int h = 0; h < hold_extra && bus.host_req; h++) begin
      tick;
      chk("ack_held", bus.host_ack, 1);
    end
    bus.host_req = 1'b0;
    tick;
    chk("ack_drop", bus.host_ack, 0);
    chk("idle_busy2", bus.busy, 0);
    chk("idle_count_held", bus.cycle_count, exp_cnt);
    chk("idle_to_held", bus.timed_out, exp_to);
  endtask
  initial begin
    int d, c;
    bit t;
    tab[0] = '{4, 0, 0, 0, 2, 4, 1'b0};
    tab[1] = '{0, 0, 0, 0, 6, 10, 1'b1};
    tab[2] = '{1, 0, 0, 0, 0, 1, 1'b0};
    tab[3] = '{10, 0, 0, 0, 0, 10, 1'b0};
    tab[4] = '{11, 0, 0, 0, 3, 10, 1'b1};
    tab[5] = '{6, 3, 1, 0, 0, 6, 1'b0};
    tab[6] = '{0, 0, 0, 8, 0, 0, 1'b0};
    tab[7] = '{5, 0, 0, 0, 0, 5, 1'b0};
    bus.host_req = 1'b0;
    bus.cpu_pc   = '0;
    tick;
    tick;
    chk_cleared("reset");
    reset = 1'b0;
    tick;
    chk_cleared("post_reset");
    foreach (tab[i])
      run_one(tab[i].done_at, tab[i].drop_at, tab[i].junk, tab[i].rst_at,
              tab[i].hold, tab[i].cnt, tab[i].to);
    for (int n = 0; n < 40; n++) begin
      d = $urandom_range(0, 14);
      t = !(d != 0 && d <= TO);
      c = t ? TO : d;
      run_one(d, $urandom_range(0, 12), 1'($urandom_range(0, 1)), 0,
              $urandom_range(0, 4), c, t);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
